// File: rtl/cellram_stream_reader_pkg.sv
// Shared definitions for cellram_control clients: bus widths and the stream
// reader's state encoding.
package cellram_stream_reader_pkg;

   localparam int CR_WORD_W = 16;
   localparam int CR_ADDR_W = 24;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_ARM    = 3'd2,
      ST_WAITRD = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_EMPTY  = 3'd5
   } rd_state_t;

endpackage

// File: rtl/cellram_sync_fifo.sv
// Counter-based synchronous FIFO with first-word fall-through head and a
// single-cycle flush. Push and pop together on a full FIFO is legal.
module cellram_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == CNT_FULL);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   overflow_chk: assert property (@(posedge clk) disable iff (rst)
      !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/cellram_stream_reader.sv
// Turns a (base, length) job into sequential single-word cellram reads with
// one read in flight, streaming the returned words out through a FIFO.
module cellram_stream_reader
   import cellram_stream_reader_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 23
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic [CR_ADDR_W-1:0]          base_addr,
   input  logic [LEN_W-1:0]              length,
   output logic                          busy,
   output logic                          done,
   output logic [CR_WORD_W-1:0]          out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CR_ADDR_W-1:0]          cr__addr,
   output logic [CR_WORD_W-1:0]          cr__data_in,
   output logic                          cr__read,
   output logic                          cr__write,
   input  logic [CR_WORD_W-1:0]          cr__data_out,
   input  logic                          cr__wait,
   output logic [2:0]                    dbg_state,
   output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_count
);

   localparam logic [CR_ADDR_W-1:0] ADDR_STEP = 2;
   localparam logic [LEN_W-1:0]     LEN_ONE   = 1;

   rd_state_t            state_q;
   logic [CR_ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]     remaining_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 cr_read_q;
   logic [CR_ADDR_W-1:0] cr_addr_q;

   logic                 fifo_push;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 in_flight;
   logic                 unused_base_bit0;

   assign unused_base_bit0 = base_addr[0];

   // A read is outstanding in ARM/WAITRD; aborting there must wait it out.
   assign in_flight = (state_q == ST_ARM) || (state_q == ST_WAITRD) || (state_q == ST_DRAIN);
   assign fifo_push = (state_q == ST_WAITRD) && !cr__wait && !abort;

   cellram_sync_fifo #(
      .WIDTH (CR_WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (fifo_push),
      .pop_i     (out_ready),
      .flush_i   (abort),
      .wr_data_i (cr__data_out),
      .rd_data_o (out_data),
      .count_o   (dbg_fifo_count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cr_read_q   <= 1'b0;
         cr_addr_q   <= '0;
      end else begin
         done_q    <= 1'b0;
         cr_read_q <= 1'b0;
         if (abort) begin
            state_q <= in_flight ? ST_DRAIN : ST_IDLE;
            busy_q  <= in_flight;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     busy_q <= 1'b1;
                     if (length != '0) begin
                        addr_q      <= {base_addr[CR_ADDR_W-1:1], 1'b0};
                        remaining_q <= length;
                        state_q     <= ST_ISSUE;
                     end else begin
                        state_q <= ST_EMPTY;
                     end
                  end
               end
               ST_EMPTY: begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
               ST_ISSUE: begin
                  // Nothing is in flight here, so a free slot covers the next word.
                  if (!fifo_full && !cr__wait) begin
                     cr_read_q <= 1'b1;
                     cr_addr_q <= addr_q;
                     state_q   <= ST_ARM;
                  end
               end
               ST_ARM: state_q <= ST_WAITRD;
               ST_WAITRD: begin
                  if (!cr__wait) begin
                     addr_q      <= addr_q + ADDR_STEP;
                     remaining_q <= remaining_q - LEN_ONE;
                     if (remaining_q == LEN_ONE) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                     end else begin
                        state_q <= ST_ISSUE;
                     end
                  end
               end
               ST_DRAIN: begin
                  if (!cr__wait) begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign out_valid   = ~fifo_empty;
   assign cr__read    = cr_read_q;
   assign cr__addr    = cr_addr_q;
   assign cr__data_in = '0;
   assign cr__write   = 1'b0;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_cellram_stream_reader.sv
// Directed bench for cellram_stream_reader with a behavioural cellram
// responder (fixed latency) and a scoreboard of expected addresses and words.
module tb_cellram_stream_reader;
   import cellram_stream_reader_pkg::*;

   localparam int LEN_W = 23;
   localparam int LAT   = 3;

   logic        clk = 1'b0;
   logic        rst, start, abort, out_ready;
   logic [23:0] base_addr;
   logic [LEN_W-1:0] length;
   logic        busy, done, out_valid, cr__read, cr__write, cr__wait;
   logic [15:0] out_data, cr__data_in, cr__data_out;
   logic [23:0] cr__addr;
   logic [2:0]  dbg_state;
   logic [4:0]  dbg_fifo_count;

   int checks = 0;
   int errors = 0;
   int reads = 0;
   int done_cnt = 0;

   logic [15:0] mem [int];
   logic [23:0] addr_log[$];
   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];
   logic [23:0] exp_addr_q[$];

   logic [23:0] pend_addr;
   int          lat_cnt;

   always #10 clk = ~clk;

   cellram_stream_reader #(.FIFO_DEPTH(16), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .base_addr(base_addr), .length(length), .busy(busy), .done(done),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .cr__addr(cr__addr), .cr__data_in(cr__data_in), .cr__read(cr__read),
      .cr__write(cr__write), .cr__data_out(cr__data_out), .cr__wait(cr__wait),
      .dbg_state(dbg_state), .dbg_fifo_count(dbg_fifo_count)
   );

   function automatic logic [15:0] mem_rd(input logic [23:0] a);
      int k;
      k = int'(a[23:1]);
      return mem.exists(k) ? mem[k] : 16'hDEAD;
   endfunction

   // Responder: wait rises the cycle after the request, data valid LAT cycles later.
   always @(posedge clk) begin
      if (rst) begin
         cr__wait     <= 1'b0;
         lat_cnt      <= 0;
         cr__data_out <= 16'h0000;
      end else if (cr__read) begin
         cr__wait  <= 1'b1;
         lat_cnt   <= LAT;
         pend_addr <= cr__addr;
      end else if (lat_cnt != 0) begin
         lat_cnt <= lat_cnt - 1;
         if (lat_cnt == 1) begin
            cr__wait     <= 1'b0;
            cr__data_out <= mem_rd(pend_addr);
         end
      end
   end

   always @(negedge clk) begin
      if (cr__read) begin
         addr_log.push_back(cr__addr);
         reads++;
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [23:0] b, input logic [LEN_W-1:0] l);
      @(posedge clk); #1;
      base_addr = b;
      length    = l;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < max) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("%s idle", tag), {31'd0, busy}, 32'd0);
   endtask

   task automatic check_job(input string tag, input int a0, input int g0, input int r0);
      int n;
      n = exp_q.size();
      check($sformatf("%s reads", tag), reads - r0, n);
      check($sformatf("%s words", tag), got_q.size() - g0, n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s addr%0d", tag, i), {8'd0, addr_log[a0+i]}, {8'd0, exp_addr_q[i]});
         check($sformatf("%s data%0d", tag, i), {16'd0, got_q[g0+i]}, {16'd0, exp_q[i]});
      end
      exp_q.delete();
      exp_addr_q.delete();
   endtask

   initial begin
      int a0, g0, r0, d0, found;
      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      base_addr = '0; length = '0;

      mem[24'h1000 >> 1] = 16'h1111;
      mem[24'h1002 >> 1] = 16'h2222;
      mem[24'h1004 >> 1] = 16'h3333;
      mem[24'h1006 >> 1] = 16'h4444;
      for (int i = 0; i < 20; i++) mem[(24'h2000 >> 1) + i] = 16'hA000 + 16'(i);
      mem[24'hFFFFFE >> 1] = 16'hBEEF;
      mem[0]               = 16'hCAFE;
      mem[24'h3000 >> 1]   = 16'h1234;
      mem[24'h3002 >> 1]   = 16'h5678;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst busy", {31'd0, busy}, 0);
      check("rst done", {31'd0, done}, 0);
      check("rst out_valid", {31'd0, out_valid}, 0);
      check("rst cr_read", {31'd0, cr__read}, 0);
      check("rst cr_addr", {8'd0, cr__addr}, 0);
      check("rst cr_write", {31'd0, cr__write}, 0);
      check("rst cr_data_in", {16'd0, cr__data_in}, 0);
      check("rst state", {29'd0, dbg_state}, ST_IDLE);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;

      // Basic four-word job
      a0 = addr_log.size(); g0 = got_q.size(); r0 = reads; d0 = done_cnt;
      exp_addr_q = '{24'h1000, 24'h1002, 24'h1004, 24'h1006};
      exp_q      = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      start_job(24'h1000, 4);
      wait_idle("job4", 300);
      repeat (5) @(negedge clk);
      check_job("job4", a0, g0, r0);
      check("job4 done", done_cnt - d0, 1);
      check("job4 busy", {31'd0, busy}, 0);

      // Empty job: busy one cycle, then done
      r0 = reads; d0 = done_cnt;
      start_job(24'h1000, 0);
      @(negedge clk);
      check("len0 busy1", {31'd0, busy}, 1);
      check("len0 done_early", {31'd0, done}, 0);
      @(negedge clk);
      check("len0 done", {31'd0, done}, 1);
      check("len0 busy0", {31'd0, busy}, 0);
      @(negedge clk);
      check("len0 done_pulse", {31'd0, done}, 0);
      check("len0 reads", reads - r0, 0);
      check("len0 out_valid", {31'd0, out_valid}, 0);
      check("len0 done_cnt", done_cnt - d0, 1);

      // Back-pressure: only FIFO_DEPTH reads until the consumer drains
      @(posedge clk); #1;
      out_ready = 1'b0;
      a0 = addr_log.size(); g0 = got_q.size(); r0 = reads;
      for (int i = 0; i < 20; i++) begin
         exp_addr_q.push_back(24'h2000 + 24'(2 * i));
         exp_q.push_back(16'hA000 + 16'(i));
      end
      start_job(24'h2000, 20);
      repeat (300) @(negedge clk);
      check("bp reads16", reads - r0, 16);
      check("bp cr_read", {31'd0, cr__read}, 0);
      check("bp state", {29'd0, dbg_state}, ST_ISSUE);
      check("bp count", {27'd0, dbg_fifo_count}, 16);
      check("bp head", {16'd0, out_data}, 32'h0000A000);
      check("bp busy", {31'd0, busy}, 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_idle("bp", 500);
      repeat (5) @(negedge clk);
      check_job("bp", a0, g0, r0);

      // Address wrap at the top of the 24-bit space
      a0 = addr_log.size(); g0 = got_q.size(); r0 = reads;
      exp_addr_q = '{24'hFFFFFE, 24'h000000};
      exp_q      = '{16'hBEEF, 16'hCAFE};
      start_job(24'hFFFFFE, 2);
      wait_idle("wrap", 200);
      repeat (5) @(negedge clk);
      check_job("wrap", a0, g0, r0);

      // Abort while a read is outstanding
      r0 = reads;
      start_job(24'h2000, 8);
      found = 0;
      for (int n = 0; n < 200 && found == 0; n++) begin
         @(negedge clk);
         if ((reads - r0) >= 2 && dbg_state == ST_WAITRD && cr__wait) found = 1;
      end
      check("abort reach_waitrd", found, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      d0 = done_cnt; r0 = reads;
      @(negedge clk);
      check("abort state", {29'd0, dbg_state}, ST_DRAIN);
      check("abort out_valid", {31'd0, out_valid}, 0);
      check("abort busy", {31'd0, busy}, 1);
      wait_idle("abort", 50);
      check("abort cr_wait", {31'd0, cr__wait}, 0);
      repeat (3) @(negedge clk);
      check("abort reads", reads - r0, 0);
      check("abort no_done", done_cnt - d0, 0);
      check("abort fifo_empty", {31'd0, out_valid}, 0);
      a0 = addr_log.size(); g0 = got_q.size(); r0 = reads;
      exp_addr_q = '{24'h3000, 24'h3002};
      exp_q      = '{16'h1234, 16'h5678};
      start_job(24'h3001, 2);
      wait_idle("post_abort", 200);
      repeat (5) @(negedge clk);
      check_job("post_abort", a0, g0, r0);

      // A second start while busy is ignored
      a0 = addr_log.size(); g0 = got_q.size(); r0 = reads; d0 = done_cnt;
      exp_addr_q = '{24'h1000, 24'h1002, 24'h1004, 24'h1006};
      exp_q      = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      start_job(24'h1000, 4);
      repeat (3) @(negedge clk);
      start_job(24'h5000, 1);
      wait_idle("restart", 300);
      repeat (10) @(negedge clk);
      check_job("restart", a0, g0, r0);
      check("restart done", done_cnt - d0, 1);

      // Reset mid-job
      @(posedge clk); #1;
      out_ready = 1'b0;
      start_job(24'h2000, 20);
      repeat (40) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("midrst busy", {31'd0, busy}, 0);
      check("midrst done", {31'd0, done}, 0);
      check("midrst out_valid", {31'd0, out_valid}, 0);
      check("midrst cr_read", {31'd0, cr__read}, 0);
      check("midrst cr_addr", {8'd0, cr__addr}, 0);
      check("midrst state", {29'd0, dbg_state}, ST_IDLE);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
